// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 reads as zero; a same-cycle write is forwarded to any read port that matches it.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        wEn,
    input  logic [4:0]  wReg,
    input  logic [31:0] wData,
    input  logic [4:0]  Reg0,
    input  logic [4:0]  Reg1,
    output logic [31:0] Reg0Out,
    output logic [31:0] Reg1Out
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_live;
    logic        byp0;
    logic        byp1;

    // A write only takes effect (and only forwards) when it targets a real register outside reset.
    assign wr_live = wEn && !rst && (wReg != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_live) begin
            regs_d[wReg] = wData;
        end
        regs_d[0] = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign byp0 = wr_live && (wReg == Reg0);
    assign byp1 = wr_live && (wReg == Reg1);

    always_comb begin
        Reg0Out = 32'h0;
        if (Reg0 != 5'd0) begin
            Reg0Out = byp0 ? wData : regs_q[Reg0];
        end
    end

    always_comb begin
        Reg1Out = 32'h0;
        if (Reg1 != 5'd0) begin
            Reg1Out = byp1 ? wData : regs_q[Reg1];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file: expectations come from an array model of R[0..31]
// and are queued by the driver, then popped and compared by a monitor on the falling clock edge.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        wEn;
    logic [4:0]  wReg;
    logic [31:0] wData;
    logic [4:0]  Reg0;
    logic [4:0]  Reg1;
    logic [31:0] Reg0Out;
    logic [31:0] Reg1Out;

    register_file dut (
        .clk    (clk),
        .rst    (rst),
        .wEn    (wEn),
        .wReg   (wReg),
        .wData  (wData),
        .Reg0   (Reg0),
        .Reg1   (Reg1),
        .Reg0Out(Reg0Out),
        .Reg1Out(Reg1Out)
    );

    typedef struct {
        logic [31:0] exp0;
        logic [31:0] exp1;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [32];
    int          total;
    int          bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic r, input logic we,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && !r && wr == idx) return wd;
        return mem[idx];
    endfunction

    // Drive one cycle: queue the expected combinational reads, then advance the model over the edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1, input string tag);
        exp_t e;
        rst   = r;
        wEn   = we;
        wReg  = wr;
        wData = wd;
        Reg0  = r0;
        Reg1  = r1;
        e.exp0 = model_read(r0, r, we, wr, wd);
        e.exp1 = model_read(r1, r, we, wr, wd);
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            mem[wr] = wd;
        end
        #1;
    endtask

    initial begin
        exp_t e;
        int   guard;
        logic r;
        logic we;
        logic [4:0] wr;
        logic [4:0] r0;
        logic [4:0] r1;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 'x;
        rst = 1'b0; wEn = 1'b0; wReg = '0; wData = '0; Reg0 = '0; Reg1 = '0;

        fork
            forever begin
                @(negedge clk);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    total++;
                    if (Reg0Out !== e.exp0) begin
                        bad++;
                        $display("FAIL %s port0: got %h expected %h", e.tag, Reg0Out, e.exp0);
                    end
                    total++;
                    if (Reg1Out !== e.exp1) begin
                        bad++;
                        $display("FAIL %s port1: got %h expected %h", e.tag, Reg1Out, e.exp1);
                    end
                end
            end
        join_none

        @(posedge clk);
        #1;

        drive(1, 0, 0, 32'h0, 0, 0, "reset_idx0");
        drive(1, 0, 0, 32'h0, 5, 31, "reset_idx5_31");
        drive(0, 0, 0, 32'h0, 5, 31, "after_reset");

        for (int i = 0; i < 32; i++) drive(0, 1, 5'(i), 32'(i), 5'(i), 5'(31 - i), "write_all");
        for (int i = 0; i < 32; i++) drive(0, 0, 5'($urandom), $urandom, 5'(i), 5'(31 - i), "read_all");

        for (int i = 0; i < 32; i++) drive(0, 0, 5'(i), 32'hBEEEBEEE, 5'(i), 5'(i), "wen_off");
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 32'h0, 5'(i), 5'(i), "wen_off_check");

        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, "r0_write_same");
        drive(0, 0, 0, 32'h0, 0, 0, "r0_after");

        drive(0, 0, 0, 32'h0, 7, 7, "r7_before");
        drive(0, 1, 7, 32'hCAFEF00D, 7, 7, "bypass");
        drive(0, 0, 7, 32'h0, 7, 7, "bypass_after");

        drive(0, 1, 3, 32'h12345678, 3, 9, "r3_write");
        drive(1, 1, 3, 32'hAAAAAAAA, 3, 5, "reset_vs_write");
        drive(0, 0, 3, 32'hAAAAAAAA, 3, 5, "after_mid_reset");

        drive(0, 1, 12, 32'h11111111, 12, 12, "b2b_first");
        drive(0, 1, 12, 32'h22222222, 4, 12, "b2b_second");
        drive(0, 0, 0, 32'h0, 12, 12, "b2b_result");

        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            drive(r, we, wr, $urandom, r0, r1, "random");
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file for the CPU datapath, with two asynchronous read ports and one synchronous write port. It sits between instruction decode (which supplies the source and destination register indices) and writeback (which supplies the result data). Register 0 is hardwired to zero. A same-cycle write is forwarded to both read ports.

## Interface
Parameters: none. Depth is fixed at 32 and width at 32.

- clk  input  1  system clock; all state updates happen on the rising edge
- rst  input  1  synchronous reset, active-high; clears every register on a rising clk edge
- wEn  input  1  write enable; when 1, wData is written to register wReg on the rising edge
- wReg  input  5  write register index
- wData  input  32  write data
- Reg0  input  5  read port 0 register index
- Reg1  input  5  read port 1 register index
- Reg0Out  output  32  read port 0 data
- Reg1Out  output  32  read port 1 data

## Operation
- Storage: registers R[0..31], 32 bits each.
- Reset: if rst=1 at a rising clk edge, all R[i] are set to 0.
  - Reset has priority over any write in the same cycle.
- Write: if rst=0 and wEn=1 at a rising clk edge, R[wReg] takes the value of wData.
  - If wReg=0, the write is discarded. R[0] is always 0.
- No write: if wEn=0, no register changes, whatever values wReg and wData hold.
- Read, combinational: each read port drives R[index] with no clock involved.
  - If the index is 0, the port drives 32'h0.
- Bypass, per port: if wEn=1, rst=0, wReg≠0 and wReg equals that port's index, the port drives wData instead of the stored value.
  - This makes a write visible to a read in the same cycle.
- Ports are independent:
  - Reg0 and Reg1 may be equal, and both ports then return the same value.
  - Both ports may bypass at the same time.
- Read outputs never show X after the first reset edge.

## Timing
- Write latency: one clock.
  - The value is stored at the rising edge.
  - It is readable without bypass from that edge onward.
- Read latency: zero. The output is a combinational function of:
  - the index inputs,
  - the stored state,
  - the bypass inputs (wEn, wReg, wData, rst).
- Reset value of both outputs after a reset edge with wEn=0 is 32'h0, for every index.
- If rst is asserted mid-sequence, all previously written values are lost at that edge. Reads then return 0 until new writes occur.
- Back-to-back writes to the same register in consecutive cycles: the last write wins.

## Test plan
- Reset: hold rst=1 for one rising edge with wEn=0 and Reg0=Reg1=0 -> Reg0Out=Reg1Out=32'h0.
  - Repeat the reset with Reg0=5 and Reg1=31 -> both outputs still 0.
- Write all, then read: with wEn=1, write wData=i to wReg=i for i=0..31, then set wEn=0.
  - Read Reg0=i, Reg1=31−i -> Reg0Out=i and Reg1Out=31−i.
  - Index 0 reads 0 on either port.
- Write disabled: with wEn=0, drive wReg=0..31 with wData=32'hBEEEBEEE.
  - Read Reg0=Reg1=i -> both outputs equal i; no register is corrupted.
- Register 0 protection: write wReg=0 with wData=32'hFFFFFFFF and wEn=1, then read index 0 on both ports -> 32'h0.
  - Reading index 0 in the same cycle as that write also returns 0, because no bypass applies to index 0.
- Bypass: with R[7]=7, set wEn=1, wReg=7, wData=32'hCAFEF00D and Reg0=Reg1=7.
  - Before the edge, both outputs show 32'hCAFEF00D.
  - After the edge with wEn=0, both outputs still show 32'hCAFEF00D.
- Reset mid-operation: write 32'h12345678 to R[3], then pulse rst=1 for one edge while wEn=1, wReg=3, wData=32'hAAAAAAAA -> Reg0=3 reads 32'h0 after the edge.
